buf_swap_ctrl: RTL and testbench

BUF_SWAP_CTRL -- requirements
Module: buf_swap_ctrl

---
 rtl/buf_swap_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_buf_swap_ctrl.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/buf_swap_ctrl.sv
// Double-buffer swap controller: triggers a back-buffer refill every frame_div vsyncs,
// arbitrates filler/host writes, and swaps buffers on vsync. Optional macro: BUF_SWAP_CTRL_TIMEOUT_EN.
module buf_swap_ctrl #(
  parameter int width      = 128,
  parameter int height     = 48,
  parameter int char_width = 8,
  parameter int frame_div  = 60,
  localparam int XW = (width  > 1) ? $clog2(width)  : 1,
  localparam int YW = (height > 1) ? $clog2(height) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  vsync,
  input  logic                  clear_req,
  input  logic                  fill_we,
  input  logic [XW-1:0]         fill_x,
  input  logic [YW-1:0]         fill_y,
  input  logic [char_width-1:0] fill_c,
  input  logic                  host_req,
  input  logic [XW-1:0]         host_x,
  input  logic [YW-1:0]         host_y,
  input  logic [char_width-1:0] host_c,
  output logic                  refresh,
  output logic                  zero_buf,
  output logic                  host_gnt,
  output logic                  mem_we,
  output logic [XW-1:0]         mem_x,
  output logic [YW-1:0]         mem_y,
  output logic [char_width-1:0] mem_c,
  output logic                  mem_sel,
  output logic                  front_sel,
  output logic                  busy
`ifdef BUF_SWAP_CTRL_TIMEOUT_EN
  , output logic                fill_err
`endif
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FILL    = 2'd1,
    WAIT_VS = 2'd2,
    SWAP    = 2'd3
  } state_t;

  localparam logic [7:0] CNT_LAST = 8'(frame_div - 1);

  state_t     state_q;
  logic [7:0] vs_cnt_q;
  logic [7:0] vs_cnt_d;
  logic       vs_wrap_s;
  logic       pending_q;
  logic       clr_q;
  logic       we_prev_q;
  logic       refresh_q;
  logic       zero_buf_q;
  logic       front_sel_q;
  logic       busy_q;

`ifdef BUF_SWAP_CTRL_TIMEOUT_EN
  localparam int WD_LIMIT = width * height + 8;
  localparam int WDW      = $clog2(WD_LIMIT + 2);
  logic [WDW-1:0] wd_q;
  logic           fill_err_q;
  assign fill_err = fill_err_q;
`endif

  assign refresh   = refresh_q;
  assign zero_buf  = zero_buf_q;
  assign front_sel = front_sel_q;
  assign busy      = busy_q;
  assign mem_sel   = ~front_sel_q;

  // Frame counter next value; wrap marks a refill opportunity.
  always_comb begin
    vs_wrap_s = vsync & (vs_cnt_q == CNT_LAST);
    if (!vsync) begin
      vs_cnt_d = vs_cnt_q;
    end else if (vs_wrap_s) begin
      vs_cnt_d = 8'd0;
    end else begin
      vs_cnt_d = vs_cnt_q + 8'd1;
    end
  end

  // Back-buffer write arbitration: filler wins, host locked out during the swap cycle.
  always_comb begin
    host_gnt = host_req & ~fill_we & (state_q != SWAP);
    mem_we   = fill_we | host_gnt;
    if (fill_we) begin
      mem_x = fill_x;
      mem_y = fill_y;
      mem_c = fill_c;
    end else begin
      mem_x = host_x;
      mem_y = host_y;
      mem_c = host_c;
    end
  end

  // Controller FSM with registered refresh/zero_buf/front_sel/busy.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      vs_cnt_q    <= 8'd0;
      pending_q   <= 1'b0;
      clr_q       <= 1'b0;
      we_prev_q   <= 1'b0;
      refresh_q   <= 1'b0;
      zero_buf_q  <= 1'b0;
      front_sel_q <= 1'b0;
      busy_q      <= 1'b0;
`ifdef BUF_SWAP_CTRL_TIMEOUT_EN
      wd_q        <= '0;
      fill_err_q  <= 1'b0;
`endif
    end else begin
      vs_cnt_q  <= vs_cnt_d;
      refresh_q <= 1'b0;
      if (clear_req) begin
        clr_q <= 1'b1;
      end else begin
        clr_q <= clr_q;
      end
      if (vs_wrap_s) begin
        pending_q <= 1'b1;
      end else begin
        pending_q <= pending_q;
      end

      case (state_q)
        IDLE: begin
          if (pending_q) begin
            // A wrap landing on the consume cycle is dropped: pending was already set.
            pending_q  <= 1'b0;
            refresh_q  <= 1'b1;
            zero_buf_q <= clr_q | clear_req;
            clr_q      <= 1'b0;
            we_prev_q  <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= FILL;
`ifdef BUF_SWAP_CTRL_TIMEOUT_EN
            wd_q       <= '0;
`endif
          end else begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        FILL: begin
          we_prev_q <= fill_we;
`ifdef BUF_SWAP_CTRL_TIMEOUT_EN
          wd_q      <= wd_q + 1'b1;
`endif
          if (we_prev_q & ~fill_we) begin
            state_q <= WAIT_VS;
            busy_q  <= 1'b1;
`ifdef BUF_SWAP_CTRL_TIMEOUT_EN
          end else if (wd_q >= WDW'(WD_LIMIT)) begin
            state_q    <= IDLE;
            busy_q     <= 1'b0;
            zero_buf_q <= 1'b0;
            fill_err_q <= 1'b1;
`endif
          end else begin
            state_q <= FILL;
            busy_q  <= 1'b1;
          end
        end
        WAIT_VS: begin
          busy_q <= 1'b1;
          if (vsync) begin
            state_q <= SWAP;
          end else begin
            state_q <= WAIT_VS;
          end
        end
        SWAP: begin
          front_sel_q <= ~front_sel_q;
          zero_buf_q  <= 1'b0;
          busy_q      <= 1'b0;
          state_q     <= IDLE;
        end
        default: begin
          zero_buf_q <= 1'b0;
          busy_q     <= 1'b0;
          state_q    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_buf_swap_ctrl.sv
// Directed self-checking bench for buf_swap_ctrl (width=4, height=2, frame_div=2).
module tb_buf_swap_ctrl;

  localparam int W  = 4;
  localparam int H  = 2;
  localparam int CW = 8;
  localparam int FD = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          vsync;
  logic          clear_req;
  logic          fill_we;
  logic [1:0]    fill_x;
  logic [0:0]    fill_y;
  logic [CW-1:0] fill_c;
  logic          host_req;
  logic [1:0]    host_x;
  logic [0:0]    host_y;
  logic [CW-1:0] host_c;
  logic          refresh;
  logic          zero_buf;
  logic          host_gnt;
  logic          mem_we;
  logic [1:0]    mem_x;
  logic [0:0]    mem_y;
  logic [CW-1:0] mem_c;
  logic          mem_sel;
  logic          front_sel;
  logic          busy;
`ifdef BUF_SWAP_CTRL_TIMEOUT_EN
  logic          fill_err;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  buf_swap_ctrl #(.width(W), .height(H), .char_width(CW), .frame_div(FD)) dut (
    .clk(clk), .reset(reset), .vsync(vsync), .clear_req(clear_req),
    .fill_we(fill_we), .fill_x(fill_x), .fill_y(fill_y), .fill_c(fill_c),
    .host_req(host_req), .host_x(host_x), .host_y(host_y), .host_c(host_c),
    .refresh(refresh), .zero_buf(zero_buf), .host_gnt(host_gnt),
    .mem_we(mem_we), .mem_x(mem_x), .mem_y(mem_y), .mem_c(mem_c),
    .mem_sel(mem_sel), .front_sel(front_sel), .busy(busy)
`ifdef BUF_SWAP_CTRL_TIMEOUT_EN
    , .fill_err(fill_err)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_vsync();
    vsync = 1'b1;
    cyc();
    vsync = 1'b0;
  endtask

  initial begin
    reset = 1'b1; vsync = 1'b0; clear_req = 1'b0; fill_we = 1'b0;
    fill_x = 2'd0; fill_y = 1'd0; fill_c = 8'd0;
    host_req = 1'b0; host_x = 2'd0; host_y = 1'd0; host_c = 8'd0;
    #2 reset = 1'b0;
    #1;
    check("rst_refresh", refresh, 32'd0);
    check("rst_zero_buf", zero_buf, 32'd0);
    check("rst_busy", busy, 32'd0);
    check("rst_front_sel", front_sel, 32'd0);
    check("rst_mem_sel", mem_sel, 32'd1);
    cyc(); cyc();
    reset = 1'b1;
    cyc();

    // Refresh cadence: two vsyncs per refill
    pulse_vsync();
    cyc();
    check("cad_v1_busy", busy, 32'd0);
    check("cad_v1_refresh", refresh, 32'd0);
    pulse_vsync();
    check("cad_idle_refresh", refresh, 32'd0);
    check("cad_idle_busy", busy, 32'd0);
    cyc();
    check("cad_refresh", refresh, 32'd1);
    check("cad_busy", busy, 32'd1);
    check("cad_zero_buf", zero_buf, 32'd0);
    cyc();
    check("cad_refresh_one", refresh, 32'd0);
    cyc();
    check("fill_no_early_done", busy, 32'd1);

    // Fill with host contention, then host wins once filler idles
    host_req = 1'b1; host_x = 2'd3; host_y = 1'd1; host_c = 8'hA5;
    for (int i = 0; i < 8; i++) begin
      fill_we = 1'b1;
      fill_x  = 2'(i);
      fill_y  = 1'(i >> 2);
      fill_c  = 8'(8'h30 + i);
      #1;
      check("arb_fill_gnt", host_gnt, 32'd0);
      check("arb_fill_x", mem_x, 32'(i % 4));
      if (i == 0) begin
        check("arb_fill_c", mem_c, 32'h30);
        check("arb_fill_we", mem_we, 32'd1);
        check("arb_mem_sel", mem_sel, 32'd1);
      end else begin
        check("arb_fill_y", mem_y, 32'(i >> 2));
      end
      cyc();
    end
    fill_we = 1'b0;
    #1;
    check("arb_host_gnt", host_gnt, 32'd1);
    check("arb_host_c", mem_c, 32'hA5);
    check("arb_host_x", mem_x, 32'd3);
    check("arb_host_we", mem_we, 32'd1);
    cyc();
    check("wait_busy", busy, 32'd1);
    check("wait_front", front_sel, 32'd0);
    cyc(); cyc();
    check("wait_hold", busy, 32'd1);
    vsync = 1'b1;
    #1;
    check("wait_host_gnt", host_gnt, 32'd1);
    cyc();
    vsync = 1'b0;
    #1;
    check("swap_deny", host_gnt, 32'd0);
    check("swap_busy", busy, 32'd1);
    check("swap_front_pre", front_sel, 32'd0);
    cyc();
    check("swap_idle", busy, 32'd0);
    check("swap_front", front_sel, 32'd1);
    check("swap_mem_sel", mem_sel, 32'd0);
    host_req = 1'b0;

    // Clear request makes the next refill a blank one
    clear_req = 1'b1;
    cyc();
    clear_req = 1'b0;
    cyc();
    check("clr_no_start", busy, 32'd0);
    pulse_vsync();
    cyc();
    check("clr_refresh", refresh, 32'd1);
    check("clr_zb_refresh", zero_buf, 32'd1);
    fill_we = 1'b1;
    cyc();
    check("clr_zb_fill0", zero_buf, 32'd1);
    cyc();
    check("clr_zb_fill1", zero_buf, 32'd1);
    fill_we = 1'b0;
    cyc();
    check("clr_zb_wait", zero_buf, 32'd1);
    check("clr_wait_busy", busy, 32'd1);
    pulse_vsync();
    check("clr_zb_swap", zero_buf, 32'd1);
    cyc();
    check("clr_zb_idle", zero_buf, 32'd0);
    check("clr_front", front_sel, 32'd0);
    pulse_vsync();
    cyc();
    check("clr2_refresh", refresh, 32'd1);
    check("clr2_zb", zero_buf, 32'd0);
    fill_we = 1'b1;
    cyc();
    check("clr2_zb_fill", zero_buf, 32'd0);

    // Asynchronous reset during FILL, with a refill pending
    pulse_vsync();
    pulse_vsync();
    #2 reset = 1'b0;
    #1;
    check("mrst_refresh", refresh, 32'd0);
    check("mrst_zero_buf", zero_buf, 32'd0);
    check("mrst_busy", busy, 32'd0);
    check("mrst_front", front_sel, 32'd0);
    check("mrst_mem_sel", mem_sel, 32'd1);
    fill_we = 1'b0;
    cyc();
    reset = 1'b1;
    cyc(); cyc(); cyc();
    check("mrst_pending_clr", busy, 32'd0);
    check("mrst_no_refresh", refresh, 32'd0);
    pulse_vsync();
    cyc(); cyc();
    check("mrst_cnt_clr", busy, 32'd0);
    pulse_vsync();
    cyc();
    check("mrst_refresh_again", refresh, 32'd1);
    check("mrst_busy_again", busy, 32'd1);

`ifdef BUF_SWAP_CTRL_TIMEOUT_EN
    // Watchdog: filler never drops write_en
    fill_we = 1'b1;
    check("wd_err_init", fill_err, 32'd0);
    for (int i = 0; i < 16; i++) begin
      cyc();
    end
    check("wd_busy_17", busy, 32'd1);
    check("wd_err_17", fill_err, 32'd0);
    cyc();
    check("wd_err", fill_err, 32'd1);
    check("wd_idle", busy, 32'd0);
    check("wd_front", front_sel, 32'd0);
    check("wd_zero_buf", zero_buf, 32'd0);
    fill_we = 1'b0;
    cyc();
    check("wd_err_sticky", fill_err, 32'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
